ysyx_22050243_wb_arbiter: RTL and testbench
===========================================

// Module: ysyx_22050243_wb_arbiter
// PURPOSE
//  Writeback initiator for the GPR write port (w_en/w_addr/w_data).
//  Merges EXU results and LSU load data into one registered write per cycle.
//  Sign- or zero-extends load data to register width.
//  Keeps a per-register pending scoreboard (busy) that decode uses to stall on RAW hazards.
// PARAMETERS
//  ADDR_WIDTH  5   GPR index width; the register file holds 2**ADDR_WIDTH entries
//  DATA_WIDTH  64  register width
//  EXU_DEPTH   2   EXU result buffer depth; power of two, >=2
// PORTS
//  clk           in   1            sole clock; all state updates on rising edge
//  rst_n         in   1            asynchronous, active-low reset
//  flush         in   1            pipeline flush (synchronous)
//  alloc_en      in   1            decode issued an instruction that writes alloc_rd
//  alloc_rd      in   ADDR_WIDTH   destination register being allocated
//  exu_valid     in   1            EXU result offered
//  exu_ready     out  1            EXU result accepted when valid&ready
//  exu_rd        in   ADDR_WIDTH   EXU destination
//  exu_data      in   DATA_WIDTH   EXU result
//  lsu_valid     in   1            load result offered
//  lsu_ready     out  1            load result accepted when valid&ready
//  lsu_rd        in   ADDR_WIDTH   load destination
//  lsu_data      in   DATA_WIDTH   raw load data, right-aligned
//  lsu_size      in   2            0=B 1=H 2=W 3=D
//  lsu_unsigned  in   1            1 = zero-extend, 0 = sign-extend
//  gpr_w_en      out  1            GPR write enable (registered)
//  gpr_w_addr    out  ADDR_WIDTH   GPR write index (registered)
//  gpr_w_data    out  DATA_WIDTH   GPR write data (registered)
//  busy          out  2**ADDR_WIDTH  pending-write bitmap (registered)
// BEHAVIOUR
//  - Reset (rst_n=0, async): gpr_w_en/addr/data=0, busy=0, EXU buffer empty.
//    In-flight results are dropped. After release, exu_ready=1.
//  - EXU path: results enter an EXU_DEPTH FIFO. exu_ready = !fifo_full (combinational from FIFO state).
//    A push and a pop in the same cycle are allowed when full.
//  - Arbitration, once per cycle:
//    - FIFO full and non-empty: the FIFO head wins and lsu_ready=0 (anti-starvation).
//    - Otherwise lsu_valid wins and lsu_ready=1.
//    - Otherwise a non-empty FIFO pops its head.
//    - lsu_ready is combinational; it does not depend on lsu_valid.
//  - Output: the winner is registered. gpr_w_* update on the next edge, so latency from accept to write is 1 cycle.
//    If there is no winner, gpr_w_en=0 next cycle; addr/data hold their previous values.
//  - rd==0: the result is consumed normally, but gpr_w_en=0 and busy is unaffected.
//  - Load extension by lsu_size: take the low 8/16/32/64 bits.
//    Fill the upper bits with the MSB of that field if lsu_unsigned=0, else with zeros.
//    lsu_size=3 passes the data through unchanged.
//  - Scoreboard:
//    - busy[alloc_rd] is set on alloc_en (rd!=0).
//    - busy[rd] is cleared on the edge that loads a gpr_w_en=1 write for rd.
//    - Set and clear of the same rd in one cycle: set wins.
//    - busy[0] is always 0.
//    - One outstanding writer per rd; decode guarantees this by stalling on busy.
//  - flush=1: FIFO emptied, busy cleared to 0, and an alloc in the same cycle is ignored.
//    The output register still completes the write already selected this cycle.
//    The LSU handshake is unaffected; a load accepted during flush is still written.
// STRUCTURE
//  - Package ysyx_22050243_pkg holds the LSU_SZ_B/H/W/D encodings, REG_ZERO, and the wb_entry struct {rd, data}.
//  - Sub-module ysyx_22050243_wb_fifo: synchronous FIFO (EXU_DEPTH, wb_entry), async active-low reset,
//    full/empty flags, flush input.
//  - Top level: arbiter, extension mux, output registers, busy bitmap.
// TESTING
//  1. Reset, then exu_valid one cycle with rd=5, data=0x1234:
//     next cycle gpr_w_en=1, addr=5, data=0x1234; busy[5] cleared if it was allocated.
//  2. LSU rd=7, data=0x80, size=B: unsigned=0 gives data 0xFFFF_FFFF_FFFF_FF80;
//     the same input with unsigned=1 gives 0x80. Repeat for the H/W boundaries 0x8000 and 0x8000_0000.
//  3. lsu_valid held high while EXU pushes 3 results:
//     FIFO fills, exu_ready=0, the head then wins with lsu_ready=0 for one cycle;
//     all 3 EXU results plus every load are written in order with none lost.
//  4. alloc_en rd=9 in the same cycle a write to rd=9 is registered: busy[9]=1 afterwards.
//     alloc rd=0 and an EXU write to rd=0 give busy[0]=0 and gpr_w_en=0.
//  5. FIFO holding 2 entries and busy=0x0000_0600, then flush=1:
//     FIFO empty and busy=0 next cycle; no writes from the flushed entries appear.
//  6. Assert rst_n=0 asynchronously mid-burst:
//     all outputs 0 immediately, no write after release until a new handshake.

Source files
------------

// File: rtl/ysyx_22050243_pkg.sv
// Shared definitions for the GPR writeback stage: load size encodings,
// the zero register index and the buffered writeback entry.
package ysyx_22050243_pkg;

    localparam int WB_ADDR_W = 5;
    localparam int WB_DATA_W = 64;

    localparam logic [1:0] LSU_SZ_B = 2'd0;
    localparam logic [1:0] LSU_SZ_H = 2'd1;
    localparam logic [1:0] LSU_SZ_W = 2'd2;
    localparam logic [1:0] LSU_SZ_D = 2'd3;

    localparam logic [WB_ADDR_W-1:0] REG_ZERO = '0;

    // One pending register write: destination index and value.
    typedef struct packed {
        logic [WB_ADDR_W-1:0] rd;
        logic [WB_DATA_W-1:0] data;
    } wb_entry;

endpackage

// File: rtl/ysyx_22050243_wb_fifo.sv
// Small synchronous FIFO that buffers EXU results while the LSU owns the
// write port. DEPTH must be a power of two so the pointers wrap on their own.
// A push is still taken when full as long as a pop happens in the same cycle.
module ysyx_22050243_wb_fifo
    import ysyx_22050243_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    flush,
    input  logic    push,
    input  wb_entry push_data,
    input  logic    pop,
    output wb_entry head,
    output logic    full,
    output logic    empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    wb_entry       mem [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; flush discards everything buffered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are only meaningful where count says so.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ysyx_22050243_wb_arbiter.sv
// GPR writeback arbiter: merges buffered EXU results with LSU load data into
// one registered write per cycle, extends load data, and tracks a pending
// write bitmap that decode uses to stall on RAW hazards.
//
// Handshakes: a result transfers on a rising edge where valid && ready are
// both high. ready never depends on the matching valid, and a producer keeps
// valid and its payload stable until the transfer happens.
module ysyx_22050243_wb_arbiter
    import ysyx_22050243_pkg::*;
#(
    parameter int ADDR_WIDTH = WB_ADDR_W,
    parameter int DATA_WIDTH = WB_DATA_W,
    parameter int EXU_DEPTH  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     alloc_en,
    input  logic [ADDR_WIDTH-1:0]    alloc_rd,
    input  logic                     exu_valid,
    output logic                     exu_ready,
    input  logic [ADDR_WIDTH-1:0]    exu_rd,
    input  logic [DATA_WIDTH-1:0]    exu_data,
    input  logic                     lsu_valid,
    output logic                     lsu_ready,
    input  logic [ADDR_WIDTH-1:0]    lsu_rd,
    input  logic [DATA_WIDTH-1:0]    lsu_data,
    input  logic [1:0]               lsu_size,
    input  logic                     lsu_unsigned,
    output logic                     gpr_w_en,
    output logic [ADDR_WIDTH-1:0]    gpr_w_addr,
    output logic [DATA_WIDTH-1:0]    gpr_w_data,
    output logic [2**ADDR_WIDTH-1:0] busy
);

    wb_entry                  fifo_head;
    wb_entry                  fifo_in;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     fifo_push;
    logic                     fifo_pop;
    logic                     exu_bypass;
    logic [DATA_WIDTH-1:0]    lsu_ext;
    logic                     sel_valid;
    logic [ADDR_WIDTH-1:0]    sel_rd;
    logic [DATA_WIDTH-1:0]    sel_data;
    logic                     sel_wr;
    logic [2**ADDR_WIDTH-1:0] busy_next;

    // A full buffer always drains its head, which is what blocks the LSU and
    // keeps a steady load stream from starving EXU results.
    assign exu_ready = !fifo_full;
    assign lsu_ready = !fifo_full;

    // With nothing buffered and no load competing, an EXU result skips the
    // buffer so it reaches the register file on the very next edge.
    assign exu_bypass = exu_valid && fifo_empty && !lsu_valid;
    assign fifo_push  = exu_valid && exu_ready && !exu_bypass;
    assign fifo_pop   = !fifo_empty && (fifo_full || !lsu_valid);
    assign fifo_in    = '{rd: exu_rd, data: exu_data};

    ysyx_22050243_wb_fifo #(
        .DEPTH(EXU_DEPTH)
    ) u_exu_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (fifo_push),
        .push_data (fifo_in),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Extend the right-aligned load field to register width.
    always_comb begin
        lsu_ext = lsu_data;
        case (lsu_size)
            LSU_SZ_B: lsu_ext = {{(DATA_WIDTH-8){~lsu_unsigned & lsu_data[7]}},   lsu_data[7:0]};
            LSU_SZ_H: lsu_ext = {{(DATA_WIDTH-16){~lsu_unsigned & lsu_data[15]}}, lsu_data[15:0]};
            LSU_SZ_W: lsu_ext = {{(DATA_WIDTH-32){~lsu_unsigned & lsu_data[31]}}, lsu_data[31:0]};
            default:  lsu_ext = lsu_data;
        endcase
    end

    // Pick this cycle's winner: full buffer head, then load, then buffer, then bypass.
    always_comb begin
        sel_valid = 1'b0;
        sel_rd    = '0;
        sel_data  = '0;
        if (fifo_full) begin
            sel_valid = 1'b1;
            sel_rd    = fifo_head.rd;
            sel_data  = fifo_head.data;
        end else if (lsu_valid) begin
            sel_valid = 1'b1;
            sel_rd    = lsu_rd;
            sel_data  = lsu_ext;
        end else if (!fifo_empty) begin
            sel_valid = 1'b1;
            sel_rd    = fifo_head.rd;
            sel_data  = fifo_head.data;
        end else if (exu_valid) begin
            sel_valid = 1'b1;
            sel_rd    = exu_rd;
            sel_data  = exu_data;
        end
    end

    // Writes to x0 are consumed but never reach the register file.
    assign sel_wr = sel_valid && (sel_rd != REG_ZERO);

    // Register the winner; address and data hold when nothing wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gpr_w_en   <= 1'b0;
            gpr_w_addr <= '0;
            gpr_w_data <= '0;
        end else begin
            gpr_w_en <= sel_wr;
            if (sel_valid) begin
                gpr_w_addr <= sel_rd;
                gpr_w_data <= sel_data;
            end
        end
    end

    // Next pending bitmap: clear on write, then set on alloc so set wins.
    always_comb begin
        busy_next = busy;
        if (sel_wr) busy_next[sel_rd] = 1'b0;
        if (alloc_en && (alloc_rd != REG_ZERO)) busy_next[alloc_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    // Pending bitmap register; flush drops every outstanding allocation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else if (flush) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

endmodule

// File: tb/tb_ysyx_22050243_wb_arbiter.sv
// Directed bench for the writeback arbiter: hand-computed vectors for
// extension, arbitration order, scoreboard, flush and async reset.
`timescale 1ns/1ps
module tb_ysyx_22050243_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        alloc_en;
    logic [4:0]  alloc_rd;
    logic        exu_valid;
    logic        exu_ready;
    logic [4:0]  exu_rd;
    logic [63:0] exu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [63:0] lsu_data;
    logic [1:0]  lsu_size;
    logic        lsu_unsigned;
    logic        gpr_w_en;
    logic [4:0]  gpr_w_addr;
    logic [63:0] gpr_w_data;
    logic [31:0] busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] exp_q[$];

    ysyx_22050243_wb_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .alloc_en     (alloc_en),
        .alloc_rd     (alloc_rd),
        .exu_valid    (exu_valid),
        .exu_ready    (exu_ready),
        .exu_rd       (exu_rd),
        .exu_data     (exu_data),
        .lsu_valid    (lsu_valid),
        .lsu_ready    (lsu_ready),
        .lsu_rd       (lsu_rd),
        .lsu_data     (lsu_data),
        .lsu_size     (lsu_size),
        .lsu_unsigned (lsu_unsigned),
        .gpr_w_en     (gpr_w_en),
        .gpr_w_addr   (gpr_w_addr),
        .gpr_w_data   (gpr_w_data),
        .busy         (busy)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic idle_inputs();
        flush        = 1'b0;
        alloc_en     = 1'b0;
        alloc_rd     = '0;
        exu_valid    = 1'b0;
        exu_rd       = '0;
        exu_data     = '0;
        lsu_valid    = 1'b0;
        lsu_rd       = '0;
        lsu_data     = '0;
        lsu_size     = 2'd3;
        lsu_unsigned = 1'b0;
    endtask

    task automatic drive_exu(input logic [4:0] rd, input logic [63:0] data);
        exu_valid = 1'b1;
        exu_rd    = rd;
        exu_data  = data;
    endtask

    task automatic drive_lsu(input logic [4:0] rd, input logic [63:0] data,
                             input logic [1:0] size, input logic uns);
        lsu_valid    = 1'b1;
        lsu_rd       = rd;
        lsu_data     = data;
        lsu_size     = size;
        lsu_unsigned = uns;
    endtask

    task automatic drive_alloc(input logic [4:0] rd);
        alloc_en = 1'b1;
        alloc_rd = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // extension vectors: data, size, unsigned, expected
    logic [63:0] ext_din [8] = '{64'h80, 64'h80, 64'h8000, 64'h8000,
                                 64'h8000_0000, 64'h8000_0000,
                                 64'h1234_5678_9ABC_DE7F, 64'h8123_4567_89AB_CDEF};
    logic [1:0]  ext_sz  [8] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd0, 2'd3};
    logic        ext_un  [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [63:0] ext_exp [8] = '{64'hFFFF_FFFF_FFFF_FF80, 64'h80,
                                 64'hFFFF_FFFF_FFFF_8000, 64'h8000,
                                 64'hFFFF_FFFF_8000_0000, 64'h8000_0000,
                                 64'h7F, 64'h8123_4567_89AB_CDEF};

    // burst vectors: lsu_v, lsu_rd, exu_v, exu_rd, expected exu_ready, lsu_ready
    logic       b_lv [8] = '{1, 1, 1, 1, 1, 1, 0, 0};
    logic [4:0] b_lr [8] = '{12, 14, 16, 16, 18, 18, 0, 0};
    logic       b_ev [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
    logic [4:0] b_er [8] = '{13, 15, 17, 17, 0, 0, 0, 0};
    logic       b_xr [8] = '{1, 1, 0, 1, 0, 1, 1, 1};
    logic       b_yr [8] = '{1, 1, 0, 1, 0, 1, 1, 1};

    initial begin
        int          nwr;
        logic [63:0] e;
        string       tag;

        // reset
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_w_en", gpr_w_en, 0);
        check("rst_w_addr", gpr_w_addr, 0);
        check("rst_w_data", gpr_w_data, 0);
        check("rst_busy", busy, 0);
        check("rst_exu_ready", exu_ready, 1);
        check("rst_lsu_ready", lsu_ready, 1);

        // 1: single EXU result
        @(negedge clk); idle_inputs(); drive_alloc(5);
        tick();
        check("t1_busy_set", busy, 32'h20);
        @(negedge clk); idle_inputs(); drive_exu(5, 64'h1234);
        #1 check("t1_exu_ready", exu_ready, 1);
        tick();
        check("t1_w_en", gpr_w_en, 1);
        check("t1_w_addr", gpr_w_addr, 5);
        check("t1_w_data", gpr_w_data, 64'h1234);
        check("t1_busy_clr", busy, 0);
        @(negedge clk); idle_inputs();
        tick();
        check("t1_idle_en", gpr_w_en, 0);
        check("t1_hold_addr", gpr_w_addr, 5);

        // 2: load extension
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); idle_inputs(); drive_lsu(7, ext_din[i], ext_sz[i], ext_un[i]);
            tick();
            tag = $sformatf("t2_ext%0d", i);
            check(tag, gpr_w_data, ext_exp[i]);
            check({tag, "_en"}, gpr_w_en, 1);
        end
        check("t2_addr", gpr_w_addr, 7);

        // 3: loads held high while EXU fills the buffer
        exp_q = '{64'hB00C, 64'hB00E, 64'hA00D, 64'hB010, 64'hA00F, 64'hB012, 64'hA011};
        nwr = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk); idle_inputs();
            if (i < 8) begin
                if (b_lv[i]) drive_lsu(b_lr[i], 64'hB000 | 64'(b_lr[i]), 2'd3, 1'b0);
                if (b_ev[i]) drive_exu(b_er[i], 64'hA000 | 64'(b_er[i]));
                #1;
                check($sformatf("t3_exu_ready%0d", i), exu_ready, b_xr[i]);
                check($sformatf("t3_lsu_ready%0d", i), lsu_ready, b_yr[i]);
            end
            tick();
            if (gpr_w_en) begin
                nwr++;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check($sformatf("t3_data%0d", i), gpr_w_data, e);
                    check($sformatf("t3_addr%0d", i), gpr_w_addr, 64'(e[4:0]));
                end
            end
        end
        check("t3_writes", nwr, 7);
        check("t3_left", exp_q.size(), 0);

        // 4: scoreboard set-wins and x0
        @(negedge clk); idle_inputs(); drive_alloc(9);
        tick();
        check("t4_busy_set", busy, 32'h200);
        @(negedge clk); idle_inputs(); drive_alloc(9); drive_exu(9, 64'h99);
        tick();
        check("t4_w_en", gpr_w_en, 1);
        check("t4_w_addr", gpr_w_addr, 9);
        check("t4_set_wins", busy, 32'h200);
        @(negedge clk); idle_inputs(); drive_alloc(0); drive_exu(0, 64'h77);
        tick();
        check("t4_x0_en", gpr_w_en, 0);
        check("t4_x0_busy", busy, 32'h200);

        // 5: flush with two buffered entries
        @(negedge clk); idle_inputs(); drive_alloc(10);
        drive_lsu(20, 64'h20, 2'd3, 1'b0); drive_exu(21, 64'h21);
        tick();
        check("t5_a_addr", gpr_w_addr, 20);
        check("t5_busy", busy, 32'h600);
        @(negedge clk); idle_inputs();
        drive_lsu(22, 64'h22, 2'd3, 1'b0); drive_exu(23, 64'h23);
        tick();
        check("t5_b_addr", gpr_w_addr, 22);
        check("t5_full", exu_ready, 0);
        @(negedge clk); idle_inputs(); flush = 1'b1; drive_alloc(11);
        #1 check("t5_lsu_blocked", lsu_ready, 0);
        tick();
        check("t5_busy_clr", busy, 0);
        check("t5_empty", exu_ready, 1);
        check("t5_sel_en", gpr_w_en, 1);
        check("t5_sel_addr", gpr_w_addr, 21);
        @(negedge clk); idle_inputs();
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("t5_no_wr%0d", i), gpr_w_en, 0);
        end

        // 6: async reset mid-burst
        @(negedge clk); idle_inputs(); drive_alloc(3);
        drive_lsu(4, 64'hDEAD, 2'd3, 1'b0); drive_exu(6, 64'h66);
        tick();
        check("t6_pre_data", gpr_w_data, 64'hDEAD);
        check("t6_pre_busy", busy, 32'h8);
        @(negedge clk); idle_inputs();
        drive_lsu(5, 64'hBEEF, 2'd3, 1'b0); drive_exu(8, 64'h88);
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_en", gpr_w_en, 0);
        check("t6_rst_addr", gpr_w_addr, 0);
        check("t6_rst_data", gpr_w_data, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_ready", exu_ready, 1);
        @(negedge clk); idle_inputs();
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("t6_quiet%0d", i), gpr_w_en, 0);
        end
        @(negedge clk); idle_inputs(); drive_lsu(4, 64'h44, 2'd3, 1'b0);
        tick();
        check("t6_new_en", gpr_w_en, 1);
        check("t6_new_data", gpr_w_data, 64'h44);
        @(negedge clk); idle_inputs();
        tick();

        // report
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
